tbuf_bus_arb: RTL and testbench

Round-robin arbiter and sequencer for a shared tristate bus built from per-requester TBUF cells. Grants one of N requesters ownership of the bus at a time. Drives each requester's TBUF active-low enable directly from registers. Enforces a fully tristated turnaround gap between owners so no two drivers ever overlap; an optional hold limit prevents one requester starving the others.

---
 rtl/tbuf_bus_arb_pkg.sv | 23 ++
 rtl/tbuf_bus_arb_rr_pick.sv | 27 ++
 rtl/tbuf_bus_arb.sv | 116 +++++++++++
 tb/tb_tbuf_bus_arb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tbuf_bus_arb_pkg.sv
// Shared definitions for the tristate bus arbiter: FSM encodings, counter widths
// and a constant clog2 helper used to size ports and counters.
package tbuf_bus_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_DRIVE = 2'b01;
    localparam state_t ST_GAP   = 2'b10;

    // Turnaround counter holds TURN values up to 15
    localparam int GAP_W = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tbuf_bus_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo N; returns one-hot winner, its index and an any-valid flag.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_onehot,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % N]) begin
                o_any                              = 1'b1;
                o_onehot[(int'(i_ptr) + k) % N]    = 1'b1;
                o_idx                              = W'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/tbuf_bus_arb.sv
// Round-robin owner sequencer for a shared TBUF bus. GNT and the active-low TBUF
// enables come straight from flops, with a fully tristated gap between owners.
module tbuf_bus_arb
    import tbuf_bus_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TURN    = 1,
    parameter int MAXHOLD = 16
) (
    input  logic                  CK,
    input  logic                  CD,
    input  logic [N-1:0]          REQ,
    output logic [N-1:0]          GNT,
    output logic [N-1:0]          T,
    output logic [clog2(N)-1:0]   OWNER,
    output logic                  BUSY
);

    localparam int OWN_W  = clog2(N);
    localparam int HOLD_W = (MAXHOLD > 0) ? clog2(MAXHOLD + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(MAXHOLD);
    localparam logic [GAP_W-1:0]  TURN_INIT = GAP_W'(TURN);
    localparam logic [OWN_W-1:0]  LAST_IDX  = OWN_W'(N - 1);

    state_t              r_state;
    logic [N-1:0]        r_gnt;
    logic [N-1:0]        r_t;
    logic [OWN_W-1:0]    r_owner;
    logic                r_busy;
    logic [OWN_W-1:0]    r_ptr;
    logic [HOLD_W-1:0]   r_hold;
    logic [GAP_W-1:0]    r_gap;

    logic [N-1:0]        w_onehot;
    logic [OWN_W-1:0]    w_idx;
    logic                w_any;
    logic                w_release;
    logic                w_expire;

    rr_pick #(
        .N (N),
        .W (OWN_W)
    ) u_pick (
        .i_req    (REQ),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    assign w_release = ~REQ[r_owner];
    assign w_expire  = (MAXHOLD != 0) && (r_hold == HOLD_LIM);

    // Async reset tristates every driver immediately, without waiting for a clock
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_t     <= '1;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_gap   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_DRIVE;
                        r_gnt   <= w_onehot;
                        r_t     <= ~w_onehot;
                        r_owner <= w_idx;
                        r_busy  <= 1'b1;
                        r_hold  <= HOLD_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (w_release || w_expire) begin
                        r_gnt   <= '0;
                        r_t     <= '1;
                        r_busy  <= 1'b0;
                        r_owner <= '0;
                        r_hold  <= '0;
                        r_ptr   <= (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
                        if (TURN > 0) begin
                            r_state <= ST_GAP;
                            r_gap   <= TURN_INIT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (r_hold != '1) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap <= GAP_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_gap   <= '0;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign GNT   = r_gnt;
    assign T     = r_t;
    assign OWNER = r_owner;
    assign BUSY  = r_busy;

endmodule

// File: tb/tb_tbuf_bus_arb.sv
// Self-checking bench for tbuf_bus_arb: directed vector table, reset, round-robin
// and preemption sequences, plus a random contention run on a TURN=0 instance.
module tb_tbuf_bus_arb;

    logic       ck;
    logic       cd;
    logic [3:0] reqA, gntA, tA, reqB, gntB, tB, reqC, gntC, tC;
    logic [1:0] ownerA, ownerB, ownerC;
    logic       busyA, busyB, busyC;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] t;
        logic [1:0] owner;
        logic       busy;
    } vec_t;

    vec_t tbl[15];

    tbuf_bus_arb #(.N(4), .TURN(1), .MAXHOLD(4)) dutA (
        .CK(ck), .CD(cd), .REQ(reqA), .GNT(gntA), .T(tA), .OWNER(ownerA), .BUSY(busyA)
    );

    tbuf_bus_arb #(.N(4), .TURN(1), .MAXHOLD(0)) dutB (
        .CK(ck), .CD(cd), .REQ(reqB), .GNT(gntB), .T(tB), .OWNER(ownerB), .BUSY(busyB)
    );

    tbuf_bus_arb #(.N(4), .TURN(0), .MAXHOLD(3)) dutC (
        .CK(ck), .CD(cd), .REQ(reqC), .GNT(gntC), .T(tC), .OWNER(ownerC), .BUSY(busyC)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Drive one requester vector, then wait for the edge and settle 1 time unit past it
    task automatic applyStimulus(input int which, input logic [3:0] req);
        case (which)
            0:       reqA = req;
            1:       reqB = req;
            default: reqC = req;
        endcase
        @(posedge ck);
        #1;
    endtask

    // Compare every output of one instance against bench-computed expectations
    task automatic checkOutput(input string name,
                               input logic [3:0] actG, input logic [3:0] actT,
                               input logic [1:0] actO, input logic actB,
                               input logic [3:0] expG, input logic [3:0] expT,
                               input logic [1:0] expO, input logic expB);
        checks++;
        if (actG !== expG || actT !== expT || actO !== expO || actB !== expB) begin
            failures++;
            $display("[TB] FAIL %s: got GNT=%b T=%b OWNER=%0d BUSY=%b, want GNT=%b T=%b OWNER=%0d BUSY=%b",
                     name, actG, actT, actO, actB, expG, expT, expO, expB);
        end
    endtask

    task automatic pulseReset();
        cd = 1'b1;
        #2;
        cd = 1'b0;
    endtask

    // Main sequence: reset, directed table, round-robin, unlimited hold, random contention
    initial begin
        logic [3:0] prevT;
        logic [3:0] oh;
        int         owner;

        checks   = 0;
        failures = 0;
        reqA = '0;
        reqB = '0;
        reqC = '0;
        cd   = 1'b1;
        #2;
        checkOutput("resetA", gntA, tA, ownerA, busyA, 4'b0000, 4'b1111, 2'd0, 1'b0);
        checkOutput("resetB", gntB, tB, ownerB, busyB, 4'b0000, 4'b1111, 2'd0, 1'b0);
        checkOutput("resetC", gntC, tC, ownerC, busyC, 4'b0000, 4'b1111, 2'd0, 1'b0);
        @(negedge ck);
        cd = 1'b0;

        applyStimulus(0, 4'b0010);
        checkOutput("preRstGrant", gntA, tA, ownerA, busyA, 4'b0010, 4'b1101, 2'd1, 1'b1);
        cd = 1'b1;
        #1;
        checkOutput("asyncReset", gntA, tA, ownerA, busyA, 4'b0000, 4'b1111, 2'd0, 1'b0);
        #1;
        cd = 1'b0;
        applyStimulus(0, 4'b0100);
        checkOutput("postRstGrant", gntA, tA, ownerA, busyA, 4'b0100, 4'b1011, 2'd2, 1'b1);
        pulseReset();

        tbl[0]  = '{4'b0100, 4'b0100, 4'b1011, 2'd2, 1'b1};
        tbl[1]  = '{4'b0100, 4'b0100, 4'b1011, 2'd2, 1'b1};
        tbl[2]  = '{4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b0};
        tbl[3]  = '{4'b0011, 4'b0000, 4'b1111, 2'd0, 1'b0};
        tbl[4]  = '{4'b0011, 4'b0001, 4'b1110, 2'd0, 1'b1};
        tbl[5]  = '{4'b0010, 4'b0000, 4'b1111, 2'd0, 1'b0};
        tbl[6]  = '{4'b0010, 4'b0000, 4'b1111, 2'd0, 1'b0};
        tbl[7]  = '{4'b0010, 4'b0010, 4'b1101, 2'd1, 1'b1};
        tbl[8]  = '{4'b1000, 4'b0000, 4'b1111, 2'd0, 1'b0};
        tbl[9]  = '{4'b1000, 4'b0000, 4'b1111, 2'd0, 1'b0};
        tbl[10] = '{4'b1000, 4'b1000, 4'b0111, 2'd3, 1'b1};
        tbl[11] = '{4'b1001, 4'b1000, 4'b0111, 2'd3, 1'b1};
        tbl[12] = '{4'b0001, 4'b0000, 4'b1111, 2'd0, 1'b0};
        tbl[13] = '{4'b0001, 4'b0000, 4'b1111, 2'd0, 1'b0};
        tbl[14] = '{4'b0001, 4'b0001, 4'b1110, 2'd0, 1'b1};
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, tbl[i].req);
            checkOutput($sformatf("vec%0d", i), gntA, tA, ownerA, busyA,
                        tbl[i].gnt, tbl[i].t, tbl[i].owner, tbl[i].busy);
        end

        // All four requesting: each owner holds 4 cycles, then 2 tristated cycles
        pulseReset();
        reqA = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            owner = g % 4;
            oh    = 4'b0001 << owner;
            for (int c = 0; c < 4; c++) begin
                applyStimulus(0, 4'b1111);
                checkOutput($sformatf("rrDrive%0d_%0d", g, c), gntA, tA, ownerA, busyA,
                            oh, ~oh, 2'(owner), 1'b1);
            end
            for (int c = 0; c < 2; c++) begin
                applyStimulus(0, 4'b1111);
                checkOutput($sformatf("rrGap%0d_%0d", g, c), gntA, tA, ownerA, busyA,
                            4'b0000, 4'b1111, 2'd0, 1'b0);
            end
        end

        // Preempted lone requester is granted again after the gap
        pulseReset();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 4'b0001);
            checkOutput($sformatf("soloDrive%0d", c), gntA, tA, ownerA, busyA,
                        4'b0001, 4'b1110, 2'd0, 1'b1);
        end
        for (int c = 0; c < 2; c++) begin
            applyStimulus(0, 4'b0001);
            checkOutput($sformatf("soloGap%0d", c), gntA, tA, ownerA, busyA,
                        4'b0000, 4'b1111, 2'd0, 1'b0);
        end
        applyStimulus(0, 4'b0001);
        checkOutput("soloRegrant", gntA, tA, ownerA, busyA, 4'b0001, 4'b1110, 2'd0, 1'b1);
        reqA = '0;

        // Unlimited hold: 5-cycle request, then a 20-cycle request
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1, 4'b0100);
            checkOutput($sformatf("single5_%0d", c), gntB, tB, ownerB, busyB,
                        4'b0100, 4'b1011, 2'd2, 1'b1);
        end
        applyStimulus(1, 4'b0000);
        checkOutput("single5Rel", gntB, tB, ownerB, busyB, 4'b0000, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1, 4'b0100);
        checkOutput("single5Gap", gntB, tB, ownerB, busyB, 4'b0000, 4'b1111, 2'd0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1, 4'b0100);
            checkOutput($sformatf("long20_%0d", c), gntB, tB, ownerB, busyB,
                        4'b0100, 4'b1011, 2'd2, 1'b1);
        end
        applyStimulus(1, 4'b0000);
        checkOutput("long20Rel", gntB, tB, ownerB, busyB, 4'b0000, 4'b1111, 2'd0, 1'b0);

        // Random contention: T mirrors GNT, at most one driver, no direct handover
        prevT = tC;
        for (int c = 0; c < 10000; c++) begin
            applyStimulus(2, 4'($urandom_range(0, 15)));
            checks++;
            if (tC !== ~gntC) begin
                failures++;
                $display("[TB] FAIL tMirror cycle %0d: got T=%b, want ~GNT=%b", c, tC, ~gntC);
            end
            checks++;
            if ($countones(~tC) > 1) begin
                failures++;
                $display("[TB] FAIL oneDriver cycle %0d: got T=%b, want at most one zero", c, tC);
            end
            checks++;
            if (prevT != 4'b1111 && tC != 4'b1111 && tC != prevT) begin
                failures++;
                $display("[TB] FAIL handover cycle %0d: got T=%b after %b, want a high-Z cycle between",
                         c, tC, prevT);
            end
            prevT = tC;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
